// File: rtl/dispatch_pkg.sv
// Shared decode constants, micro-op encodings and control types
// for the dispatch decoder.
package dispatch_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int unsigned TAG_FREE = 0;

  // uop = {group, variant, funct3}
  localparam logic [1:0] UOPG_ALU_R = 2'b00;
  localparam logic [1:0] UOPG_ALU_I = 2'b01;
  localparam logic [1:0] UOPG_LSU   = 2'b10;
  localparam logic [1:0] UOPG_BRU   = 2'b11;

  localparam logic [5:0] UOP_LUI   = 6'h18;
  localparam logic [5:0] UOP_AUIPC = 6'h19;
  localparam logic [5:0] UOP_JAL   = 6'h38;
  localparam logic [5:0] UOP_JALR  = 6'h39;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_BRU = 2'd2
  } unit_e;

  typedef enum logic [1:0] {
    RC_NORMAL  = 2'd0,
    RC_STORE   = 2'd1,
    RC_BRANCH  = 2'd2,
    RC_ILLEGAL = 2'd3
  } rob_class_e;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_SH = 3'd2,
    FMT_S  = 3'd3,
    FMT_B  = 3'd4,
    FMT_U  = 3'd5,
    FMT_J  = 3'd6
  } fmt_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    logic [5:0] op;
    unit_e      unit;
    rob_class_e rc;
    fmt_e       fmt;
    logic       wr_rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       legal;
  } uop_ctl_t;

endpackage

// File: rtl/dispatch_decoder_imm_gen.sv
// Immediate extraction for every RV32I format; shifts
// yield a zero-extended shamt.
module imm_gen
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       i_inst,
  input  fmt_e              i_fmt,
  output logic [DATA_W-1:0] o_imm
);

  logic [31:0] w_imm;
  logic        w_s;

  assign w_s = i_inst[31];

  always_comb begin
    w_imm = '0;
    unique case (i_fmt)
      FMT_I:
        w_imm = {{20{w_s}}, i_inst[31:20]};
      FMT_SH:
        w_imm = {27'd0, i_inst[24:20]};
      FMT_S:
        w_imm = {{20{w_s}}, i_inst[31:25],
                 i_inst[11:7]};
      FMT_B:
        w_imm = {{19{w_s}}, w_s, i_inst[7],
                 i_inst[30:25], i_inst[11:8],
                 1'b0};
      FMT_U:
        w_imm = {i_inst[31:12], 12'd0};
      FMT_J:
        w_imm = {{11{w_s}}, w_s,
                 i_inst[19:12], i_inst[20],
                 i_inst[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign o_imm = DATA_W'($signed(w_imm));

endmodule

// File: rtl/dispatch_decoder.sv
// RV32I decode, operand rename and a single registered
// dispatch slot feeding the ALU/LSU/BRU stations.
module dispatch_decoder
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              instValid,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] instPC,
  output logic              instReady,
  output logic [REG_W-1:0]  regAddr1,
  output logic [REG_W-1:0]  regAddr2,
  input  logic [TAG_W-1:0]  regTag1,
  input  logic [TAG_W-1:0]  regTag2,
  input  logic [DATA_W-1:0] regData1,
  input  logic [DATA_W-1:0] regData2,
  input  logic [TAG_W-1:0]  robTail,
  input  logic              robFull,
  output logic [TAG_W-1:0]  tagCheck1,
  output logic [TAG_W-1:0]  tagCheck2,
  input  logic              tag1Ready,
  input  logic              tag2Ready,
  input  logic [DATA_W-1:0] robData1,
  input  logic [DATA_W-1:0] robData2,
  input  logic              cdbValid,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData,
  output logic              robEnable,
  output logic [REG_W-1:0]  robDest,
  output logic [1:0]        robClass,
  output logic              regEnable,
  output logic [REG_W-1:0]  regTagAddr,
  output logic [TAG_W-1:0]  regTag,
  output logic              aluValid,
  output logic              lsuValid,
  output logic              bruValid,
  input  logic              aluReady,
  input  logic              lsuReady,
  input  logic              bruReady,
  output logic [OP_W-1:0]   uopOp,
  output logic [TAG_W-1:0]  uopTag1,
  output logic [TAG_W-1:0]  uopTag2,
  output logic [DATA_W-1:0] uopData1,
  output logic [DATA_W-1:0] uopData2,
  output logic [DATA_W-1:0] uopImm,
  output logic [ADDR_W-1:0] uopPC,
  output logic [TAG_W-1:0]  uopDest
);

  localparam logic [TAG_W-1:0] TFREE =
    TAG_W'(TAG_FREE);

  uop_ctl_t            w_ctl;
  logic [6:0]          w_opc;
  logic [2:0]          w_f3;
  logic [REG_W-1:0]    w_rd;
  logic [DATA_W-1:0]   w_imm;
  logic                w_nop;
  logic                w_fire;
  logic                w_accept;
  logic                w_alloc;
  logic                w_load;
  logic [TAG_W-1:0]    w_tag1;
  logic [TAG_W-1:0]    w_tag2;
  logic [DATA_W-1:0]   w_data1;
  logic [DATA_W-1:0]   w_data2;
  slot_e               r_state;
  slot_e               w_stNext;

  logic [5:0]          r_op;
  unit_e               r_unit;
  logic [TAG_W-1:0]    r_tag1;
  logic [TAG_W-1:0]    r_tag2;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   r_data2;
  logic [DATA_W-1:0]   r_imm;
  logic [ADDR_W-1:0]   r_pc;
  logic [TAG_W-1:0]    r_dest;
  logic                r_robEnable;
  logic [REG_W-1:0]    r_robDest;
  rob_class_e          r_robClass;
  logic                r_regEnable;
  logic [REG_W-1:0]    r_regTagAddr;
  logic [TAG_W-1:0]    r_regTag;

  assign w_opc = inst[6:0];
  assign w_f3  = inst[14:12];
  assign w_rd  = REG_W'(inst[11:7]);
  assign w_nop = inst == INST_NOP;

  always_comb begin
    w_ctl      = '0;
    w_ctl.rc   = RC_ILLEGAL;
    w_ctl.fmt  = FMT_R;
    w_ctl.unit = UNIT_ALU;
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_ctl.op      = {UOPG_ALU_R, inst[30], w_f3};
        w_ctl.rc      = RC_NORMAL;
        w_ctl.wr_rd   = 1'b1;
        w_ctl.use_rs1 = 1'b1;
        w_ctl.use_rs2 = 1'b1;
        w_ctl.legal   = 1'b1;
      end
      (w_opc == OPC_OPIMM): begin
        // only the right shifts carry an alt bit
        w_ctl.op = {UOPG_ALU_I,
                    inst[30] && w_f3 == 3'b101,
                    w_f3};
        w_ctl.fmt = (w_f3[1:0] == 2'b01) ?
                    FMT_SH : FMT_I;
        w_ctl.rc      = RC_NORMAL;
        w_ctl.wr_rd   = 1'b1;
        w_ctl.use_rs1 = 1'b1;
        w_ctl.legal   = 1'b1;
      end
      (w_opc == OPC_LUI),
      (w_opc == OPC_AUIPC): begin
        w_ctl.op = (w_opc == OPC_LUI) ?
                   UOP_LUI : UOP_AUIPC;
        w_ctl.fmt   = FMT_U;
        w_ctl.rc    = RC_NORMAL;
        w_ctl.wr_rd = 1'b1;
        w_ctl.legal = 1'b1;
      end
      (w_opc == OPC_LOAD): begin
        w_ctl.op      = {UOPG_LSU, 1'b0, w_f3};
        w_ctl.unit    = UNIT_LSU;
        w_ctl.fmt     = FMT_I;
        w_ctl.rc      = RC_NORMAL;
        w_ctl.wr_rd   = 1'b1;
        w_ctl.use_rs1 = 1'b1;
        w_ctl.legal   = 1'b1;
      end
      (w_opc == OPC_STORE): begin
        w_ctl.op      = {UOPG_LSU, 1'b1, w_f3};
        w_ctl.unit    = UNIT_LSU;
        w_ctl.fmt     = FMT_S;
        w_ctl.rc      = RC_STORE;
        w_ctl.use_rs1 = 1'b1;
        w_ctl.use_rs2 = 1'b1;
        w_ctl.legal   = 1'b1;
      end
      (w_opc == OPC_BRANCH): begin
        w_ctl.op      = {UOPG_BRU, 1'b0, w_f3};
        w_ctl.unit    = UNIT_BRU;
        w_ctl.fmt     = FMT_B;
        w_ctl.rc      = RC_BRANCH;
        w_ctl.use_rs1 = 1'b1;
        w_ctl.use_rs2 = 1'b1;
        w_ctl.legal   = 1'b1;
      end
      (w_opc == OPC_JAL),
      (w_opc == OPC_JALR): begin
        w_ctl.unit  = UNIT_BRU;
        w_ctl.rc    = RC_BRANCH;
        w_ctl.wr_rd = 1'b1;
        w_ctl.legal = 1'b1;
        if (w_opc == OPC_JAL) begin
          w_ctl.op  = UOP_JAL;
          w_ctl.fmt = FMT_J;
        end else begin
          w_ctl.op      = UOP_JALR;
          w_ctl.fmt     = FMT_I;
          w_ctl.use_rs1 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  imm_gen #(
    .DATA_W(DATA_W)
  ) u_imm (
    .i_inst(inst),
    .i_fmt (w_ctl.fmt),
    .o_imm (w_imm)
  );

  assign regAddr1 = w_ctl.use_rs1 ?
                    REG_W'(inst[19:15]) : '0;
  assign regAddr2 = w_ctl.use_rs2 ?
                    REG_W'(inst[24:20]) : '0;
  assign tagCheck1 = regTag1;
  assign tagCheck2 = regTag2;

  function automatic logic [TAG_W+DATA_W-1:0] resolve(
    input logic [TAG_W-1:0]  t,
    input logic              rdy,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] rob,
    input logic              cv,
    input logic [TAG_W-1:0]  ct,
    input logic [DATA_W-1:0] cd
  );
    if (t == TFREE) return {TFREE, rf};
    if (cv && ct == t) return {TFREE, cd};
    if (rdy) return {TFREE, rob};
    return {t, {DATA_W{1'b0}}};
  endfunction

  assign {w_tag1, w_data1} = resolve(
    regTag1, tag1Ready, regData1, robData1,
    cdbValid, cdbTag, cdbData);
  assign {w_tag2, w_data2} = resolve(
    regTag2, tag2Ready, regData2, robData2,
    cdbValid, cdbTag, cdbData);

  always_comb begin
    w_fire = 1'b0;
    if (r_state == S_FULL) begin
      unique case (r_unit)
        UNIT_ALU: w_fire = aluReady;
        UNIT_LSU: w_fire = lsuReady;
        UNIT_BRU: w_fire = bruReady;
        default:  w_fire = 1'b0;
      endcase
    end
  end

  assign instReady = !rst && !flush && !robFull &&
                     (r_state == S_EMPTY || w_fire);
  assign w_accept  = instValid && instReady;
  assign w_alloc   = w_accept && !w_nop;
  assign w_load    = w_alloc && w_ctl.legal;

  always_comb begin
    w_stNext = r_state;
    unique case (r_state)
      S_EMPTY:
        if (w_load) w_stNext = S_FULL;
      S_FULL:
        if (flush) w_stNext = S_EMPTY;
        else if (w_fire && !w_load)
          w_stNext = S_EMPTY;
      default: w_stNext = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_stNext;
  end

  // held slot captures late results from the CDB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_unit  <= UNIT_ALU;
      r_tag1  <= '0;
      r_tag2  <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_dest  <= '0;
    end else if (w_load) begin
      r_op    <= w_ctl.op;
      r_unit  <= w_ctl.unit;
      r_tag1  <= w_tag1;
      r_tag2  <= w_tag2;
      r_data1 <= w_data1;
      r_data2 <= w_data2;
      r_imm   <= w_imm;
      r_pc    <= instPC;
      r_dest  <= robTail;
    end else if (r_state == S_FULL) begin
      if (cdbValid && r_tag1 != TFREE &&
          cdbTag == r_tag1) begin
        r_tag1  <= TFREE;
        r_data1 <= cdbData;
      end
      if (cdbValid && r_tag2 != TFREE &&
          cdbTag == r_tag2) begin
        r_tag2  <= TFREE;
        r_data2 <= cdbData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_robEnable  <= 1'b0;
      r_regEnable  <= 1'b0;
      r_robDest    <= '0;
      r_robClass   <= RC_NORMAL;
      r_regTagAddr <= '0;
      r_regTag     <= '0;
    end else begin
      r_robEnable <= w_alloc;
      r_regEnable <= w_alloc && w_ctl.wr_rd &&
                     w_rd != '0;
      if (w_alloc) begin
        r_robDest    <= w_ctl.wr_rd ? w_rd : '0;
        r_robClass   <= w_ctl.rc;
        r_regTagAddr <= w_rd;
        r_regTag     <= robTail;
      end
    end
  end

  assign robEnable  = r_robEnable;
  assign robDest    = r_robDest;
  assign robClass   = r_robClass;
  assign regEnable  = r_regEnable;
  assign regTagAddr = r_regTagAddr;
  assign regTag     = r_regTag;

  assign aluValid = r_state == S_FULL &&
                    r_unit == UNIT_ALU;
  assign lsuValid = r_state == S_FULL &&
                    r_unit == UNIT_LSU;
  assign bruValid = r_state == S_FULL &&
                    r_unit == UNIT_BRU;

  assign uopOp    = OP_W'(r_op);
  assign uopTag1  = r_tag1;
  assign uopTag2  = r_tag2;
  assign uopData1 = r_data1;
  assign uopData2 = r_data2;
  assign uopImm   = r_imm;
  assign uopPC    = r_pc;
  assign uopDest  = r_dest;

endmodule

// File: tb/tb_dispatch_decoder.sv
// Directed checks of decode, operand resolve, stall snooping,
// backpressure, flush, special instructions and reset.
module tb_dispatch_decoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        instValid;
  logic [31:0] inst;
  logic [31:0] instPC;
  logic        instReady;
  logic [4:0]  regAddr1, regAddr2;
  logic [3:0]  regTag1, regTag2;
  logic [31:0] regData1, regData2;
  logic [3:0]  robTail;
  logic        robFull;
  logic [3:0]  tagCheck1, tagCheck2;
  logic        tag1Ready, tag2Ready;
  logic [31:0] robData1, robData2;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        robEnable;
  logic [4:0]  robDest;
  logic [1:0]  robClass;
  logic        regEnable;
  logic [4:0]  regTagAddr;
  logic [3:0]  regTag;
  logic        aluValid, lsuValid, bruValid;
  logic        aluReady, lsuReady, bruReady;
  logic [5:0]  uopOp;
  logic [3:0]  uopTag1, uopTag2;
  logic [31:0] uopData1, uopData2;
  logic [31:0] uopImm;
  logic [31:0] uopPC;
  logic [3:0]  uopDest;

  int n_cmp;
  int n_err;

  dispatch_decoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instValid(instValid), .inst(inst),
    .instPC(instPC), .instReady(instReady),
    .regAddr1(regAddr1), .regAddr2(regAddr2),
    .regTag1(regTag1), .regTag2(regTag2),
    .regData1(regData1), .regData2(regData2),
    .robTail(robTail), .robFull(robFull),
    .tagCheck1(tagCheck1), .tagCheck2(tagCheck2),
    .tag1Ready(tag1Ready), .tag2Ready(tag2Ready),
    .robData1(robData1), .robData2(robData2),
    .cdbValid(cdbValid), .cdbTag(cdbTag),
    .cdbData(cdbData),
    .robEnable(robEnable), .robDest(robDest),
    .robClass(robClass), .regEnable(regEnable),
    .regTagAddr(regTagAddr), .regTag(regTag),
    .aluValid(aluValid), .lsuValid(lsuValid),
    .bruValid(bruValid),
    .aluReady(aluReady), .lsuReady(lsuReady),
    .bruReady(bruReady),
    .uopOp(uopOp), .uopTag1(uopTag1),
    .uopTag2(uopTag2), .uopData1(uopData1),
    .uopData2(uopData2), .uopImm(uopImm),
    .uopPC(uopPC), .uopDest(uopDest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; flush = 1'b0;
    instValid = 1'b0; inst = '0; instPC = '0;
    regTag1 = '0; regTag2 = '0;
    regData1 = '0; regData2 = '0;
    robTail = 4'd3; robFull = 1'b0;
    tag1Ready = 1'b0; tag2Ready = 1'b0;
    robData1 = '0; robData2 = '0;
    cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
    aluReady = 1'b0; lsuReady = 1'b0;
    bruReady = 1'b0;
    step; step;
    chk("rst_instReady", instReady, 0);
    chk("rst_aluValid", aluValid, 0);
    chk("rst_lsuValid", lsuValid, 0);
    chk("rst_bruValid", bruValid, 0);
    chk("rst_robEnable", robEnable, 0);
    chk("rst_regEnable", regEnable, 0);
    chk("rst_uopImm", uopImm, 0);
    rst = 1'b0;

    // ADDI x5,x0,7
    inst = 32'h0070_0293; instValid = 1'b1;
    instPC = 32'h100; aluReady = 1'b1;
    #1 chk("addi_instReady", instReady, 1);
    step;
    instValid = 1'b0;
    chk("addi_aluValid", aluValid, 1);
    chk("addi_imm", uopImm, 7);
    chk("addi_tag1", uopTag1, 0);
    chk("addi_op", uopOp, 6'h10);
    chk("addi_pc", uopPC, 32'h100);
    chk("addi_dest", uopDest, 3);
    chk("addi_robEn", robEnable, 1);
    chk("addi_regEn", regEnable, 1);
    chk("addi_tagAddr", regTagAddr, 5);
    chk("addi_regTag", regTag, 3);
    chk("addi_robDest", robDest, 5);
    chk("addi_class", robClass, 0);
    step;
    chk("addi_drain", aluValid, 0);
    chk("addi_robPulse", robEnable, 0);
    chk("addi_regPulse", regEnable, 0);

    // ADD x1,x2,x3 with rs2 pending on tag 4
    inst = 32'h0031_00B3; instValid = 1'b1;
    robTail = 4'd5; regData1 = 32'h11;
    regTag2 = 4'd4; aluReady = 1'b0;
    #1;
    chk("add_rs1", regAddr1, 2);
    chk("add_rs2", regAddr2, 3);
    chk("add_probe2", tagCheck2, 4);
    step;
    instValid = 1'b0;
    chk("add_aluValid", aluValid, 1);
    chk("add_tag2", uopTag2, 4);
    chk("add_data1", uopData1, 32'h11);
    chk("add_dest", uopDest, 5);
    chk("add_robDest", robDest, 1);
    chk("add_stall0", instReady, 0);
    step;
    chk("add_stall1", instReady, 0);
    chk("add_regPulse", regEnable, 0);
    cdbValid = 1'b1; cdbTag = 4'd7;
    cdbData = 32'h99;
    step;
    chk("add_cdbMiss", uopTag2, 4);
    chk("add_stall2", instReady, 0);
    cdbTag = 4'd4; cdbData = 32'h55;
    step;
    cdbValid = 1'b0;
    chk("add_cdbTag", uopTag2, 0);
    chk("add_cdbData", uopData2, 32'h55);
    chk("add_held", aluValid, 1);
    chk("add_stall3", instReady, 0);
    aluReady = 1'b1; regTag2 = '0;
    #1 chk("add_fireReady", instReady, 1);
    step;
    chk("add_drain", aluValid, 0);
    aluReady = 1'b0;

    // BEQ x1,x2,-8: rs1 via ROB, rs2 via CDB over ROB
    inst = 32'hFE20_8CE3; instValid = 1'b1;
    robTail = 4'd2;
    regTag1 = 4'd6; tag1Ready = 1'b1;
    robData1 = 32'hAB;
    regTag2 = 4'd9; tag2Ready = 1'b1;
    robData2 = 32'hEE;
    cdbValid = 1'b1; cdbTag = 4'd9;
    cdbData = 32'h77;
    #1 chk("beq_probe1", tagCheck1, 6);
    step;
    instValid = 1'b0; cdbValid = 1'b0;
    regTag1 = '0; regTag2 = '0;
    tag1Ready = 1'b0; tag2Ready = 1'b0;
    chk("beq_bruValid", bruValid, 1);
    chk("beq_aluValid", aluValid, 0);
    chk("beq_imm", uopImm, 32'hFFFF_FFF8);
    chk("beq_op", uopOp, 6'h30);
    chk("beq_regEn", regEnable, 0);
    chk("beq_robEn", robEnable, 1);
    chk("beq_class", robClass, 2);
    chk("beq_tag1", uopTag1, 0);
    chk("beq_robData", uopData1, 32'hAB);
    chk("beq_tag2", uopTag2, 0);
    chk("beq_cdbData", uopData2, 32'h77);
    bruReady = 1'b1;
    step;
    chk("beq_drain", bruValid, 0);
    bruReady = 1'b0;

    // LW x7,4(x1) against a full ROB
    inst = 32'h0040_A383; instValid = 1'b1;
    robFull = 1'b1;
    #1 chk("full_instReady", instReady, 0);
    step;
    chk("full_robEn", robEnable, 0);
    chk("full_lsuValid", lsuValid, 0);
    robFull = 1'b0;
    #1 chk("full_release", instReady, 1);
    step;
    instValid = 1'b0;
    chk("lw_lsuValid", lsuValid, 1);
    chk("lw_imm", uopImm, 4);
    chk("lw_op", uopOp, 6'h22);
    chk("lw_tagAddr", regTagAddr, 7);

    // flush while LW is held and ADDI is offered
    inst = 32'h0070_0293; instValid = 1'b1;
    flush = 1'b1;
    #1 chk("flush_instReady", instReady, 0);
    step;
    flush = 1'b0; instValid = 1'b0;
    chk("flush_lsuValid", lsuValid, 0);
    chk("flush_aluValid", aluValid, 0);
    chk("flush_robEn", robEnable, 0);
    chk("flush_regEn", regEnable, 0);

    // unknown opcode
    inst = 32'hFFFF_FFFF; instValid = 1'b1;
    step;
    instValid = 1'b0;
    chk("ill_robEn", robEnable, 1);
    chk("ill_class", robClass, 3);
    chk("ill_robDest", robDest, 0);
    chk("ill_regEn", regEnable, 0);
    chk("ill_valids",
        {aluValid, lsuValid, bruValid}, 0);

    // canonical NOP
    inst = 32'h0000_0013; instValid = 1'b1;
    #1 chk("nop_instReady", instReady, 1);
    step;
    instValid = 1'b0;
    chk("nop_robEn", robEnable, 0);
    chk("nop_regEn", regEnable, 0);
    chk("nop_aluValid", aluValid, 0);

    // back-to-back: LUI, SRAI, JAL, SW
    aluReady = 1'b1; bruReady = 1'b1;
    inst = 32'h1234_5137; instValid = 1'b1;
    step;
    chk("lui_imm", uopImm, 32'h1234_5000);
    chk("lui_op", uopOp, 6'h18);
    chk("lui_aluValid", aluValid, 1);
    inst = 32'h4041_D193;
    #1 chk("b2b_instReady", instReady, 1);
    step;
    chk("srai_op", uopOp, 6'h1D);
    chk("srai_imm", uopImm, 4);
    chk("srai_aluValid", aluValid, 1);
    chk("srai_robEn", robEnable, 1);
    inst = 32'h0100_00EF;
    step;
    chk("jal_bruValid", bruValid, 1);
    chk("jal_aluValid", aluValid, 0);
    chk("jal_imm", uopImm, 32'h10);
    chk("jal_regEn", regEnable, 1);
    chk("jal_class", robClass, 2);
    inst = 32'hFE20_AE23;
    step;
    instValid = 1'b0;
    chk("sw_lsuValid", lsuValid, 1);
    chk("sw_imm", uopImm, 32'hFFFF_FFFC);
    chk("sw_op", uopOp, 6'h2A);
    chk("sw_class", robClass, 1);
    chk("sw_regEn", regEnable, 0);

    // asynchronous reset while SW stalls
    #2 rst = 1'b1;
    #1;
    chk("arst_lsuValid", lsuValid, 0);
    chk("arst_robEn", robEnable, 0);
    chk("arst_instReady", instReady, 0);
    step;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
